rom_port_arbiter: RTL and testbench

//  Shares the single-port instruction ROM among three requesters: instruction fetch (IF), the

---
 rtl/rom_port_arbiter_if.sv | 58 +++++
 rtl/rom_port_arbiter.sv | 117 +++++++++++
 tb/tb_rom_port_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter_if
// Description : Bundle of the requester-side and ROM-side signals of the
//               ROM port arbiter.
//                 IF : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//                 LD : ld_req/ld_addr in, ld_gnt/ld_rvalid/ld_rdata out
//                 DL : dl_req/dl_addr/dl_wdata/dl_last in, dl_gnt out
//                 ROM: rom_wr_en/rom_addr/rom_wdata out, rom_rdata in
//                 hold_o out (PC/IR stall)
//               The slave modport is the arbiter's view. The master modport
//               is the view of the environment: requesters plus the ROM.
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic              dl_req;
  logic [ADDR_W-1:0] dl_addr;
  logic [DATA_W-1:0] dl_wdata;
  logic              dl_last;
  logic              dl_gnt;

  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic [DATA_W-1:0] rom_rdata;

  logic              hold_o;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr,
    input  dl_req, dl_addr, dl_wdata, dl_last, rom_rdata,
    output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
    output dl_gnt, rom_wr_en, rom_addr, rom_wdata, hold_o
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr,
    output dl_req, dl_addr, dl_wdata, dl_last, rom_rdata,
    input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
    input  dl_gnt, rom_wr_en, rom_addr, rom_wdata, hold_o
  );
endinterface
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares a single-port synchronous-read instruction ROM among
//               instruction fetch (IF), the load port (LD) and the program
//               downloader (DL, writes). Grants are combinational with
//               priority DL > LD > IF. LD is limited to MAX_LD_RUN back-to-back
//               grants while fetch waits. A multi-beat DL burst locks the
//               ROM until its last beat. Read data is routed back one cycle
//               after the grant using a registered owner tag.
// Ports       : clk, rst (sync, active high)
//               bus - rom_port_arbiter_if.slave (requesters, ROM, hold_o)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_LD_RUN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_port_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_IF = 2'd1, TAG_LD = 2'd2} tag_t;

  // Four bits cover the whole legal MAX_LD_RUN range of 1..15.
  localparam int              RUN_W   = 4;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_LD_RUN);

  state_t            state_q;
  tag_t              tag_q;
  logic [RUN_W-1:0]  run_cnt_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ld_rdata_q;

  logic w_if_gnt;
  logic w_ld_gnt;
  logic w_dl_gnt;
  logic w_if_starved;

  // Grant selection. Reset suppresses every grant so nothing reaches the
  // ROM and no tag is captured while rst is high.
  always_comb begin
    w_if_gnt     = 1'b0;
    w_ld_gnt     = 1'b0;
    w_dl_gnt     = 1'b0;
    // Fetch has waited through a full LD run: it now beats LD (not DL).
    w_if_starved = bus.if_req && (run_cnt_q == RUN_MAX);
    if (!rst) begin
      if (state_q == ST_LOCK) begin
        w_dl_gnt = bus.dl_req;
      end else if (bus.dl_req) begin
        w_dl_gnt = 1'b1;
      end else if (bus.ld_req && !w_if_starved) begin
        w_ld_gnt = 1'b1;
      end else if (bus.if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.dl_gnt    = w_dl_gnt;

  assign bus.rom_wr_en = w_dl_gnt;
  assign bus.rom_addr  = w_dl_gnt ? bus.dl_addr :
                         w_ld_gnt ? bus.ld_addr :
                         w_if_gnt ? bus.if_addr : '0;
  assign bus.rom_wdata = w_dl_gnt ? bus.dl_wdata : '0;

  assign bus.hold_o    = !rst && ((state_q == ST_LOCK) || (bus.if_req && !w_if_gnt));

  // Response routing: the ROM word is passed straight through in the
  // tagged cycle and captured so each rdata holds between its pulses.
  assign bus.if_rvalid = !rst && (tag_q == TAG_IF);
  assign bus.ld_rvalid = !rst && (tag_q == TAG_LD);
  assign bus.if_rdata  = rst ? '0 : ((tag_q == TAG_IF) ? bus.rom_rdata : if_rdata_q);
  assign bus.ld_rdata  = rst ? '0 : ((tag_q == TAG_LD) ? bus.rom_rdata : ld_rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      tag_q      <= TAG_NONE;
      run_cnt_q  <= '0;
      if_rdata_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_ARB:  if (w_dl_gnt && !bus.dl_last) state_q <= ST_LOCK;
        ST_LOCK: if (w_dl_gnt &&  bus.dl_last) state_q <= ST_ARB;
        default: state_q <= ST_ARB;
      endcase

      if (w_if_gnt) begin
        tag_q <= TAG_IF;
      end else if (w_ld_gnt) begin
        tag_q <= TAG_LD;
      end else begin
        tag_q <= TAG_NONE;
      end

      if (!bus.if_req || w_if_gnt) begin
        run_cnt_q <= '0;
      end else if (w_ld_gnt && (run_cnt_q != RUN_MAX)) begin
        run_cnt_q <= run_cnt_q + 1'b1;
      end

      if (tag_q == TAG_IF) if_rdata_q <= bus.rom_rdata;
      if (tag_q == TAG_LD) ld_rdata_q <= bus.rom_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_port_arbiter
// Description : Self-checking bench for rom_port_arbiter. A write-first
//               synchronous ROM model answers the arbiter; a transaction
//               level reference (owner of the port, LD run length, pending
//               read, shadow memory) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_LD_RUN = 4;

  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_LD   = 2;
  localparam int G_DL   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_LD_RUN (MAX_LD_RUN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- ROM model (64 words, write-first) ----------------
  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  logic [DATA_W-1:0] rom_mem [64];
  bit                rom_wr  [64];
  logic [5:0]        rom_idx;
  assign rom_idx = bus.rom_addr[7:2];

  always @(posedge clk) begin
    if (bus.rom_wr_en) begin
      rom_mem[rom_idx] <= bus.rom_wdata;
      rom_wr[rom_idx]  <= 1'b1;
      bus.rom_rdata    <= bus.rom_wdata;
    end else begin
      bus.rom_rdata    <= rom_wr[rom_idx] ? rom_mem[rom_idx] : init_word(int'(rom_idx));
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [64];
  bit          m_lock;
  int          m_run;
  int          m_tag;
  logic [31:0] m_pend;
  logic [31:0] m_if_last;
  logic [31:0] m_ld_last;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit ifr, input logic [31:0] ifa,
                       input bit ldr, input logic [31:0] lda,
                       input bit dlr, input logic [31:0] dla,
                       input logic [31:0] dlw, input bit dll);
    rst          = r;
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.ld_req   = ldr;
    bus.ld_addr  = lda;
    bus.dl_req   = dlr;
    bus.dl_addr  = dla;
    bus.dl_wdata = dlw;
    bus.dl_last  = dll;
  endtask

  // One clock: check every output mid-cycle, then advance the model at the edge.
  task automatic tick(output int og);
    int          g;
    logic [31:0] ea;
    @(negedge clk);
    g = G_NONE;
    if (!rst) begin
      if (m_lock)                                              g = bus.dl_req ? G_DL : G_NONE;
      else if (bus.dl_req)                                     g = G_DL;
      else if (bus.ld_req && !(bus.if_req && m_run >= MAX_LD_RUN)) g = G_LD;
      else if (bus.if_req)                                     g = G_IF;
    end
    ea = (g == G_DL) ? bus.dl_addr : (g == G_LD) ? bus.ld_addr :
         (g == G_IF) ? bus.if_addr : 32'h0;
    og = bus.dl_gnt ? G_DL : bus.ld_gnt ? G_LD : bus.if_gnt ? G_IF : G_NONE;

    check_eq("gnt_vec",   32'({bus.dl_gnt, bus.ld_gnt, bus.if_gnt}),
                          32'({g == G_DL, g == G_LD, g == G_IF}));
    check_eq("rom_addr",  bus.rom_addr, ea);
    check_eq("rom_wr_en", 32'(bus.rom_wr_en), 32'(g == G_DL));
    if (g == G_DL) check_eq("rom_wdata", bus.rom_wdata, bus.dl_wdata);
    check_eq("hold_o",    32'(bus.hold_o),
             32'(!rst && (m_lock || (bus.if_req && g != G_IF))));
    check_eq("if_rvalid", 32'(bus.if_rvalid), 32'(!rst && m_tag == G_IF));
    check_eq("ld_rvalid", 32'(bus.ld_rvalid), 32'(!rst && m_tag == G_LD));
    check_eq("if_rdata",  bus.if_rdata, rst ? 32'h0 : (m_tag == G_IF) ? m_pend : m_if_last);
    check_eq("ld_rdata",  bus.ld_rdata, rst ? 32'h0 : (m_tag == G_LD) ? m_pend : m_ld_last);

    @(posedge clk);
    if (rst) begin
      m_lock    = 1'b0;
      m_run     = 0;
      m_tag     = G_NONE;
      m_if_last = 32'h0;
      m_ld_last = 32'h0;
    end else begin
      if (m_tag == G_IF) m_if_last = m_pend;
      if (m_tag == G_LD) m_ld_last = m_pend;
      m_tag = (g == G_IF || g == G_LD) ? g : G_NONE;
      if (g == G_IF || g == G_LD) m_pend = ref_mem[ea[7:2]];
      if (g == G_DL) begin
        ref_mem[bus.dl_addr[7:2]] = bus.dl_wdata;
        if (!m_lock && !bus.dl_last)     m_lock = 1'b1;
        else if (m_lock && bus.dl_last)  m_lock = 1'b0;
      end
      if (!bus.if_req || g == G_IF)              m_run = 0;
      else if (g == G_LD && m_run < MAX_LD_RUN)  m_run++;
    end
    #1;
  endtask

  initial begin
    int og;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    m_lock = 1'b0; m_run = 0; m_tag = G_NONE;
    m_pend = 32'h0; m_if_last = 32'h0; m_ld_last = 32'h0;

    // Reset
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(og); tick(og);

    // Sequential fetch 0x0, 0x4, 0x8
    for (int a = 0; a < 3; a++) begin
      drive(0, 1, 32'(a * 4), 0, 0, 0, 0, 0, 0);
      tick(og);
      check_eq("fetch_gnt", 32'(og), 32'(G_IF));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(og);

    // IF and LD held: LD,LD,LD,LD,IF repeating
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h10, 1, 32'h30, 0, 0, 0, 0);
      tick(og);
      check_eq("ld_if_pattern", 32'(og), 32'((k % 5 == 4) ? G_IF : G_LD));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(og);

    // 3-beat burst with a 2-cycle gap while fetch waits
    drive(0, 1, 32'h40, 0, 0, 1, 32'h100, 32'hA0A0_0001, 0); tick(og);
    drive(0, 1, 32'h40, 0, 0, 1, 32'h104, 32'hA0A0_0002, 0); tick(og);
    drive(0, 1, 32'h40, 0, 0, 0, 32'h108, 32'hA0A0_0003, 0); tick(og);
    check_eq("lock_gap", 32'(og), 32'(G_NONE));
    drive(0, 1, 32'h40, 0, 0, 0, 32'h108, 32'hA0A0_0003, 0); tick(og);
    drive(0, 1, 32'h40, 0, 0, 1, 32'h108, 32'hA0A0_0003, 1); tick(og);
    drive(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);                   tick(og);
    check_eq("post_burst_if", 32'(og), 32'(G_IF));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(og);

    // Write then read-back of the same address
    drive(0, 0, 0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF, 1); tick(og);
    drive(0, 0, 0, 1, 32'h20, 0, 0, 0, 0);             tick(og);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);                  tick(og);
    check_eq("ld_readback", m_ld_last, 32'hDEAD_BEEF);

    // Reset in the middle of a burst with a load pending
    drive(0, 0, 0, 0, 0, 1, 32'h80, 32'h1111_0000, 0); tick(og);
    drive(1, 0, 0, 1, 32'h24, 1, 32'h84, 32'h1111_0001, 0); tick(og);
    drive(0, 1, 32'h44, 0, 0, 0, 0, 0, 0); tick(og);
    check_eq("if_after_rst", 32'(og), 32'(G_IF));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick(og);

    // All three at once, then LD saturation and IF clearing it
    drive(0, 1, 32'h50, 1, 32'h60, 1, 32'h70, 32'h7777_7777, 1); tick(og);
    check_eq("dl_wins_all", 32'(og), 32'(G_DL));
    for (int k = 0; k < 6; k++) begin
      drive(0, 1, 32'h50, 1, 32'h60, 0, 0, 0, 0);
      tick(og);
      check_eq("sat_pattern", 32'(og), 32'((k == 4) ? G_IF : G_LD));
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 3) != 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
            ($urandom_range(0, 2) != 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
            ($urandom_range(0, 4) == 0), {24'h0, 6'($urandom_range(0, 63)), 2'b00},
            $urandom, ($urandom_range(0, 2) == 0));
      tick(og);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
